// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - selected-frame capture sequencer for a linear pixel memory
// Arms on start, skips to the chosen frame, writes every active pixel and checks line/frame geometry.
module frame_capture_ctrl #(
   parameter int H_ACTIVE   = 800,
   parameter int V_ACTIVE   = 480,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 20,
   parameter int FLIP_V     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            frame_sel,
   input  logic                  in_vs,
   input  logic                  in_de,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err_line,
   output logic                  err_frame
);
   localparam int PW = $clog2(H_ACTIVE + 2) + 1;
   localparam int LW = $clog2(V_ACTIVE + 2) + 1;
   localparam logic [PW-1:0] PIX_H    = PW'(H_ACTIVE);
   localparam logic [PW-1:0] PIX_LAST = PW'(H_ACTIVE - 1);
   localparam logic [PW-1:0] PIX_SAT  = PW'(H_ACTIVE + 1);
   localparam logic [LW-1:0] LINE_V   = LW'(V_ACTIVE);
   localparam logic [LW-1:0] LINE_SAT = LW'(V_ACTIVE + 1);
   localparam logic [ADDR_WIDTH-1:0] H_STEP    = ADDR_WIDTH'(H_ACTIVE);
   localparam logic [ADDR_WIDTH-1:0] BASE_INIT =
      (FLIP_V != 0) ? ADDR_WIDTH'((V_ACTIVE - 1) * H_ACTIVE) : '0;

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;

   state_t                state_q, state_d;
   logic                  vs_dly_q, vs_dly_d;
   logic                  de_dly_q, de_dly_d;
   logic [DATA_WIDTH-1:0] data_dly_q, data_dly_d;
   logic [3:0]            frame_cnt_q, frame_cnt_d;
   logic [3:0]            frame_sel_q, frame_sel_d;
   logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
   logic [LW-1:0]         line_cnt_q, line_cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  err_line_q, err_line_d;
   logic                  err_frame_q, err_frame_d;
   logic                  vs_rise;
   logic                  line_end;

   assign vs_rise = in_vs & ~vs_dly_q;

   always_comb begin
      state_d     = state_q;
      vs_dly_d    = in_vs;
      de_dly_d    = in_de;
      data_dly_d  = in_data;
      frame_cnt_d = frame_cnt_q;
      frame_sel_d = frame_sel_q;
      pix_cnt_d   = pix_cnt_q;
      line_cnt_d  = line_cnt_q;
      base_d      = base_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      err_line_d  = err_line_q;
      err_frame_d = err_frame_q;
      line_end    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = WAIT_FRAME;
               frame_cnt_d = '0;
               frame_sel_d = (frame_sel == 4'd0) ? 4'd1 : frame_sel;
               err_line_d  = 1'b0;
               err_frame_d = 1'b0;
            end
         end
         WAIT_FRAME: begin
            if (vs_rise) begin
               frame_cnt_d = frame_cnt_q + 4'd1;
               if (frame_cnt_q + 4'd1 == frame_sel_q) begin
                  state_d    = CAPTURE;
                  pix_cnt_d  = '0;
                  line_cnt_d = '0;
                  base_d     = BASE_INIT;
               end
            end
         end
         CAPTURE: begin
            if (de_dly_q) begin
               if (pix_cnt_q < PIX_H && line_cnt_q < LINE_V) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = base_q + ADDR_WIDTH'(pix_cnt_q);
                  wr_data_d = data_dly_q;
               end else begin
                  if (pix_cnt_q >= PIX_H) err_line_d = 1'b1;
                  if (line_cnt_q >= LINE_V) err_frame_d = 1'b1;
               end
               if (pix_cnt_q != PIX_SAT) pix_cnt_d = pix_cnt_q + 1'b1;
               // A frame start arriving on the last pixel also closes the open line.
               line_end = ~in_de | vs_rise;
            end
            if (line_end) begin
               if (pix_cnt_q != PIX_LAST) err_line_d = 1'b1;
               pix_cnt_d = '0;
               if (line_cnt_q != LINE_SAT) line_cnt_d = line_cnt_q + 1'b1;
               base_d = (FLIP_V != 0) ? base_q - H_STEP : base_q + H_STEP;
            end
            if (vs_rise) begin
               state_d = DONE;
               if (line_cnt_d != LINE_V) err_frame_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vs_dly_q    <= 1'b0;
         de_dly_q    <= 1'b0;
         data_dly_q  <= '0;
         frame_cnt_q <= '0;
         frame_sel_q <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
         base_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_dly_q    <= vs_dly_d;
         de_dly_q    <= de_dly_d;
         data_dly_q  <= data_dly_d;
         frame_cnt_q <= frame_cnt_d;
         frame_sel_q <= frame_sel_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
         base_q      <= base_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         err_line_q  <= err_line_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err_line  = err_line_q;
   assign err_frame = err_frame_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - bench for frame_capture_ctrl, flipped and unflipped instances
// Frames are described as line lengths; expected writes come from row-major geometry rules.
module tb_frame_capture_ctrl;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    frame_sel = 4'd0;
   logic          in_vs = 1'b0;
   logic          in_de = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          wr_en0, wr_en1, busy0, busy1, done0, done1, el0, el1, ef0, ef1;
   logic [AW-1:0] wr_addr0, wr_addr1;
   logic [DW-1:0] wr_data0, wr_data1;

   typedef struct {int addr; int data;} wr_t;
   wr_t q0[$];
   wr_t q1[$];
   wr_t e0, e1;
   int  log_a1[64];
   int  log_d1[64];
   int  log_a0[64];
   int  wcnt0 = 0, wcnt1 = 0, dcnt0 = 0, dcnt1 = 0;
   int  n_checks = 0, n_pass = 0;
   int  lens[8];
   int  nlines;
   int  tgt_lens[8];
   int  tgt_n;
   bit  zero_gap, start_mid;

   frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIP_V(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_sel(frame_sel),
      .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .busy(busy1), .done(done1), .err_line(el1), .err_frame(ef1));

   frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FLIP_V(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_sel(frame_sel),
      .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
      .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .busy(busy0), .done(done0), .err_line(el0), .err_frame(ef0));

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en1) begin
            if (wcnt1 < 64) begin
               log_a1[wcnt1] = int'(wr_addr1);
               log_d1[wcnt1] = int'(wr_data1);
            end
            wcnt1++;
            if (q1.size() == 0) chk("unexpected_write_flip", 1, 0);
            else begin
               e1 = q1.pop_front();
               chk("addr_flip", int'(wr_addr1), e1.addr);
               chk("data_flip", int'(wr_data1), e1.data);
            end
         end
         if (wr_en0) begin
            if (wcnt0 < 64) log_a0[wcnt0] = int'(wr_addr0);
            wcnt0++;
            if (q0.size() == 0) chk("unexpected_write_noflip", 1, 0);
            else begin
               e0 = q0.pop_front();
               chk("addr_noflip", int'(wr_addr0), e0.addr);
               chk("data_noflip", int'(wr_data0), e0.data);
            end
         end
         if (done1) dcnt1++;
         if (done0) dcnt0++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected write for line l, pixel p: suppressed outside the active geometry.
   task automatic push(input int l, input int p, input int d);
      wr_t e;
      if (l < V && p < H) begin
         e.data = d & 16'hFFFF;
         e.addr = l * H + p;
         q0.push_back(e);
         e.addr = (V - 1 - l) * H + p;
         q1.push_back(e);
      end
   endtask

   task automatic drive_frame(input int k, input int target, input int dmode);
      int idx;
      int d;
      idx = 0;
      in_vs = 1'b1; tick; in_vs = 1'b0; tick; tick;
      for (int l = 0; l < nlines; l++) begin
         for (int p = 0; p < lens[l]; p++) begin
            case (dmode)
               0:       d = idx;
               1:       d = k * 100 + idx;
               default: d = int'($urandom_range(0, 65535));
            endcase
            in_de   = 1'b1;
            in_data = DW'(d);
            start   = (start_mid && k == target && l == 1 && p == 2);
            if (k == target) push(l, p, d);
            idx++;
            tick;
         end
         in_de = 1'b0;
         start = 1'b0;
         if (!(zero_gap && l == nlines - 1)) begin
            tick; tick;
         end
      end
   endtask

   task automatic set_nominal;
      tgt_n = V;
      for (int l = 0; l < 8; l++) tgt_lens[l] = H;
      zero_gap  = 1'b0;
      start_mid = 1'b0;
   endtask

   task automatic capture(input string tag, input int fsel, input int nframes, input int dmode);
      int target;
      bit exp_el, exp_ef;
      target = (fsel == 0) ? 1 : fsel;
      exp_el = 1'b0;
      for (int l = 0; l < tgt_n; l++) if (tgt_lens[l] != H) exp_el = 1'b1;
      exp_ef = (tgt_n != V);
      q0.delete(); q1.delete();
      wcnt0 = 0; wcnt1 = 0; dcnt0 = 0; dcnt1 = 0;
      frame_sel = 4'(fsel);
      start = 1'b1; tick; start = 1'b0;
      @(negedge clk);
      chk({tag, "_busy_rise"}, int'(busy1), 1);
      chk({tag, "_err_cleared"}, int'(el1 | ef1 | el0 | ef0), 0);
      for (int k = 1; k <= nframes; k++) begin
         if (k == target) begin
            nlines = tgt_n;
            for (int l = 0; l < 8; l++) lens[l] = tgt_lens[l];
         end else begin
            nlines = V;
            for (int l = 0; l < 8; l++) lens[l] = H;
         end
         drive_frame(k, target, dmode);
      end
      in_vs = 1'b1; tick; in_vs = 1'b0;
      for (int i = 0; i < 10 && dcnt1 == 0; i++) tick;
      tick; tick; tick;
      chk({tag, "_done_flip"}, dcnt1, 1);
      chk({tag, "_done_noflip"}, dcnt0, 1);
      chk({tag, "_left_flip"}, q1.size(), 0);
      chk({tag, "_left_noflip"}, q0.size(), 0);
      chk({tag, "_err_line"}, int'(el1), int'(exp_el));
      chk({tag, "_err_frame"}, int'(ef1), int'(exp_ef));
      chk({tag, "_err_line0"}, int'(el0), int'(exp_el));
      chk({tag, "_err_frame0"}, int'(ef0), int'(exp_ef));
      chk({tag, "_busy_fall"}, int'(busy1 | busy0), 0);
   endtask

   initial begin
      #1;
      chk("rst_wr_en", int'(wr_en1 | wr_en0), 0);
      chk("rst_wr_addr", int'(wr_addr1 | wr_addr0), 0);
      chk("rst_wr_data", int'(wr_data1 | wr_data0), 0);
      chk("rst_busy", int'(busy1 | busy0), 0);
      chk("rst_done", int'(done1 | done0), 0);
      chk("rst_err", int'(el1 | ef1 | el0 | ef0), 0);
      tick; tick; tick;
      rst_n = 1'b1;
      tick;

      set_nominal;
      capture("ramp", 1, 1, 0);
      chk("ramp_count", wcnt1, 32);
      chk("ramp_first_addr", log_a1[0], 24);
      chk("ramp_first_data", log_d1[0], 0);
      chk("ramp_addr7", log_a1[7], 31);
      chk("ramp_data7", log_d1[7], 7);
      chk("ramp_addr8", log_a1[8], 16);
      chk("ramp_data8", log_d1[8], 8);
      chk("ramp_last_addr", log_a1[31], 7);
      chk("ramp_last_data", log_d1[31], 31);
      chk("ramp_noflip_last_addr", log_a0[31], 31);

      set_nominal;
      capture("sel3", 3, 4, 1);
      chk("sel3_count", wcnt1, 32);
      chk("sel3_first_data", log_d1[0], 300);
      chk("sel3_last_data", log_d1[31], 331);

      set_nominal;
      tgt_lens[1] = 7;
      capture("short", 1, 1, 0);
      chk("short_count", wcnt1, 31);
      chk("short_line2_addr", log_a1[15], 8);

      set_nominal;
      tgt_n = 5;
      capture("five", 1, 1, 0);
      chk("five_count", wcnt1, 32);

      set_nominal;
      tgt_n = 3;
      capture("three", 2, 2, 2);
      chk("three_count", wcnt1, 24);

      set_nominal;
      start_mid = 1'b1;
      capture("start_mid", 1, 2, 2);

      for (int r = 0; r < 10; r++) begin
         int fs;
         fs = int'($urandom_range(0, 3));
         tgt_n = int'($urandom_range(3, 5));
         for (int l = 0; l < 8; l++)
            tgt_lens[l] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 10)) : H;
         zero_gap  = 1'($urandom_range(0, 1));
         start_mid = 1'($urandom_range(0, 1));
         capture("rand", fs, ((fs == 0) ? 1 : fs) + int'($urandom_range(0, 1)), 2);
      end

      // Reset in the middle of a captured line.
      set_nominal;
      q0.delete(); q1.delete();
      frame_sel = 4'd1;
      start = 1'b1; tick; start = 1'b0;
      in_vs = 1'b1; tick; in_vs = 1'b0; tick; tick;
      for (int p = 0; p < 5; p++) begin
         in_de = 1'b1; in_data = DW'(p); push(0, p, p); tick;
      end
      #1;
      chk("pre_reset_wr_en", int'(wr_en1), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_busy", int'(busy1 | busy0), 0);
      chk("mid_reset_wr_en", int'(wr_en1 | wr_en0), 0);
      chk("mid_reset_wr_addr", int'(wr_addr1 | wr_addr0), 0);
      in_de = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      set_nominal;
      capture("after_reset", 1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "timeout");
   end
endmodule
